// File: rtl/unidade_controle_pkg.sv
// Shared state encoding for the game control unit and its debug display.
// Codes are fixed so the 7-segment decoder shows the documented values.
package unidade_controle_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  function automatic logic eh_final(input estado_t e);
    return (e == FIM_ACERTOU) || (e == FIM_ERROU) ||
           (e == FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Modulo counter with synchronous clear, enable and terminal-count flag.
// Used by the game control unit to bound time spent waiting for a play.
module contador_timeout #(
  parameter int MODULO = 3000,
  parameter int W      = (MODULO > 1) ? $clog2(MODULO) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

  logic [W-1:0] q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == ULTIMO) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore FSM sequencing the counter/comparator datapath of the memory game.
// Optional wait timeout is built only when TIMEOUT_EN is defined.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int ESTADO_W       = unidade_controle_pkg::ESTADO_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada,
  input  logic                igual,
  input  logic                fim,
  output logic                zera_c,
  output logic                conta_c,
  output logic                zera_r,
  output logic                registra_r,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  import unidade_controle_pkg::*;

  estado_t estado;
  estado_t prox;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

`ifdef TIMEOUT_EN
  logic em_espera;
  logic fim_tempo;

  assign em_espera = (estado == ESPERA);

  contador_timeout #(
    .MODULO(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (!em_espera),
    .conta(em_espera),
    .fim  (fim_tempo)
  );
`endif

  always_comb begin
    prox       = estado;
    zera_c     = 1'b0;
    conta_c    = 1'b0;
    zera_r     = 1'b0;
    registra_r = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    case (estado)
      INICIAL: begin
        if (iniciar) prox = PREPARACAO;
      end
      PREPARACAO: begin
        zera_c = 1'b1;
        zera_r = 1'b1;
        prox   = ESPERA;
      end
      ESPERA: begin
        if (jogada) prox = REGISTRA;
`ifdef TIMEOUT_EN
        else if (fim_tempo) prox = FIM_TIMEOUT;
`endif
      end
      REGISTRA: begin
        registra_r = 1'b1;
        prox       = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)   prox = FIM_ERROU;
        else if (fim) prox = FIM_ACERTOU;
        else          prox = PROXIMO;
      end
      PROXIMO: begin
        conta_c = 1'b1;
        prox    = ESPERA;
      end
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
`endif
      default: begin
        prox = INICIAL;
      end
    endcase
  end

  assign db_estado = ESTADO_W'(estado);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Randomized round-level bench for the game control unit.
// Timeout scenarios run when TIMEOUT_EN is defined.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim;
  logic       zera_c;
  logic       conta_c;
  logic       zera_r;
  logic       registra_r;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int nvec  = 0;
  int nerr  = 0;
  int pulsos = 0;

  unidade_controle_jogo #(
    .TIMEOUT_CICLOS(10),
    .ESTADO_W      (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fim       (fim),
    .zera_c    (zera_c),
    .conta_c   (conta_c),
    .zera_r    (zera_r),
    .registra_r(registra_r),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {zera_c,conta_c,zera_r,registra_r,pronto,acertou,errou,timeout}
  function automatic logic [7:0] saidas(input logic [3:0] c);
    case (c)
      4'h1:    return 8'b1010_0000;
      4'h4:    return 8'b0001_0000;
      4'h6:    return 8'b0100_0000;
      4'hA:    return 8'b0000_1100;
      4'hE:    return 8'b0000_1010;
      4'hD:    return 8'b0000_1011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
    if (conta_c) pulsos++;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] c);
    check({tag, "_estado"}, 32'(db_estado), 32'(c));
    check({tag, "_saidas"},
          32'({zera_c, conta_c, zera_r, registra_r,
               pronto, acertou, errou, timeout}),
          32'(saidas(c)));
  endtask

  task automatic rnd_in();
    jogada = 1'($urandom);
    iniciar = 1'($urandom);
    igual = 1'($urandom);
    fim = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iniciar = 1'b0;
    jogada = 1'b0;
    igual = 1'b0;
    fim = 1'b0;
    tick();
    expect_st("reset_ativo", 4'h0);
    tick();
    reset = 1'b0;
    tick();
    expect_st("reset_solto", 4'h0);
  endtask

  task automatic start();
    iniciar = 1'b1;
    jogada = 1'b0;
    tick();
    expect_st("preparacao", 4'h1);
    iniciar = 1'($urandom);
    jogada = 1'($urandom);
    tick();
    expect_st("espera_ini", 4'h2);
    iniciar = 1'b0;
    jogada = 1'b0;
    pulsos = 0;
  endtask

  task automatic jogar(input logic ig, input logic fm,
                       output logic [3:0] res);
    int idle;
    idle = $urandom_range(0, 5);
    for (int i = 0; i < idle; i++) begin
      iniciar = 1'($urandom);
      jogada = 1'b0;
      tick();
      expect_st("espera_idle", 4'h2);
    end
    rnd_in();
    jogada = 1'b1;
    tick();
    expect_st("registra", 4'h4);
    rnd_in();
    tick();
    expect_st("comparacao", 4'h5);
    rnd_in();
    igual = ig;
    fim = fm;
    res = !ig ? 4'hE : (fm ? 4'hA : 4'h6);
    tick();
    expect_st("resultado", res);
    if (res == 4'h6) begin
      rnd_in();
      tick();
      expect_st("volta_espera", 4'h2);
    end
    iniciar = 1'b0;
    jogada = 1'b0;
  endtask

  // Round model: position p mismatches when perde, else all 16 match
  task automatic rodada(input bit perde, input int p);
    logic [3:0] res;
    logic [3:0] alvo;
    int esperado;
    res = 4'h6;
    for (int pos = 0; pos < 16 && res == 4'h6; pos++) begin
      if (perde && pos == p)
        jogar(1'b0, 1'($urandom), res);
      else
        jogar(1'b1, pos == 15, res);
    end
    alvo = perde ? 4'hE : 4'hA;
    esperado = perde ? p : 15;
    check("fim_rodada", 32'(res), 32'(alvo));
    check("conta_pulsos", 32'(pulsos), 32'(esperado));
    repeat ($urandom_range(1, 3)) begin
      rnd_in();
      iniciar = 1'b0;
      tick();
      expect_st("final_hold", alvo);
    end
  endtask

  initial begin
    do_reset();
    start();
    rodada(1'b0, 0);
    start();
    rodada(1'b1, 3);
    start();
    for (int i = 0; i < 3; i++) begin
      iniciar = 1'b1;
      tick();
      expect_st("iniciar_em_espera", 4'h2);
    end
    iniciar = 1'b0;
    rodada(1'b1, 0);
    for (int r = 0; r < 6; r++) begin
      start();
      if ($urandom_range(0, 2) == 0) rodada(1'b0, 0);
      else rodada(1'b1, $urandom_range(0, 15));
    end

    start();
    jogada = 1'b1;
    tick();
    expect_st("pre_reset_async", 4'h4);
    jogada = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_estado", 32'(db_estado), 32'h0);
    check("async_registra_r", 32'(registra_r), 32'h0);
    tick();
    expect_st("async_hold", 4'h0);
    reset = 1'b0;
    tick();
    expect_st("async_solto", 4'h0);

`ifdef TIMEOUT_EN
    start();
    for (int i = 1; i < 10; i++) begin
      tick();
      expect_st("tmo_espera", 4'h2);
    end
    tick();
    expect_st("tmo_estouro", 4'hD);
    tick();
    expect_st("tmo_hold", 4'hD);
    start();
    for (int i = 1; i < 10; i++) begin
      tick();
      expect_st("tmo_espera2", 4'h2);
    end
    jogada = 1'b1;
    tick();
    expect_st("tmo_jogada_limite", 4'h4);
    jogada = 1'b0;
    tick();
    expect_st("tmo_comparacao", 4'h5);
    igual = 1'b1;
    fim = 1'b0;
    tick();
    expect_st("tmo_proximo", 4'h6);
    tick();
    expect_st("tmo_reespera", 4'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore FSM that sequences the counter/comparator datapath: clear, capture a player's switch entry, compare, advance the counter.
- Declares the round won when all positions match through the last address (fim), or lost on the first mismatch.
- Sits beside the datapath in the top-level circuit; drives its control inputs and reads back igual/fim.

Parameters:
- TIMEOUT_CICLOS, 3000, cycles allowed in espera before timeout (used only with TIMEOUT_EN).
- ESTADO_W, 4, width of the state register and of db_estado.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  start request; honoured only in inicial and final states.
- jogada  in  1  one-cycle pulse: player has set chaves (edge detection is upstream).
- igual  in  1  datapath comparator: memory data equals registered switches.
- fim  in  1  datapath counter rco: address is at terminal count (15).
- zera_c  out  1  synchronous clear of the address counter.
- conta_c  out  1  counter enable (enp).
- zera_r  out  1  clear of the switch register.
- registra_r  out  1  load enable of the switch register.
- pronto  out  1  round finished.
- acertou  out  1  round won.
- errou  out  1  round lost (mismatch or timeout).
- timeout  out  1  loss was caused by timeout.
- db_estado  out  ESTADO_W  current state code, for 7-segment debug.

Behaviour:
- Reset (async, any time, mid-round included): state = inicial immediately; all outputs 0; db_estado = 0; timeout counter = 0.
- All outputs are Moore, decoded from the state register only. No combinational path from any input to any output.
- State codes and transitions:
  - inicial (0): iniciar=1 -> preparacao.
  - preparacao (1): zera_c=1, zera_r=1 for exactly one cycle -> espera.
  - espera (2): jogada=1 -> registra; otherwise stay.
  - registra (4): registra_r=1 for one cycle -> comparacao.
  - comparacao (5):
    - igual=0 -> fim_errou.
    - igual=1 and fim=1 -> fim_acertou.
    - igual=1 and fim=0 -> proximo.
  - proximo (6): conta_c=1 for one cycle -> espera.
  - fim_acertou (A): pronto=1, acertou=1.
  - fim_errou (E): pronto=1, errou=1.
  - fim_timeout (D): pronto=1, errou=1, timeout=1.
  - All three final states: hold until iniciar=1 -> preparacao (restart with no reset needed).
- Timing: from jogada to result is 2 cycles (registra, comparacao); each non-final position costs 1 further cycle (proximo).
- Simultaneous events:
  - iniciar is ignored in preparacao through proximo.
  - jogada is ignored outside espera.
  - igual and fim are sampled only in comparacao.
- Unused codes (3, 7-9, B, C, F) -> inicial on the next clock.
- A full winning round is 16 matching jogadas (addresses 0..15).

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CICLOS), cleared in every state except espera, incremented each cycle in espera.
  - When it reaches TIMEOUT_CICLOS-1 with jogada=0 -> fim_timeout.
  - jogada=1 in that same cycle wins -> registra.
  - The counter restarts from 0 on each entry to espera.
- Undefined: no counter is built; timeout is tied to 0; espera waits indefinitely; code D is treated as an unused code.

Decomposition:
- Shared package/header unidade_controle_pkg holds the state code localparams (inicial..fim_timeout) and ESTADO_W, so the debug decoder and the bench share one encoding.
- One sub-module: contador_timeout (parameterised modulo counter with clear, enable and terminal-count flag), instantiated only under TIMEOUT_EN.

Test Plan:
- Reset high for 2 cycles, then low -> db_estado=0 and all outputs 0. Pulse iniciar -> one cycle with zera_c=zera_r=1, then db_estado=2.
- 16 jogadas, each with igual=1; fim=1 only on the 16th -> conta_c pulses 15 times; ends with db_estado=A, pronto=1, acertou=1.
- 3 matching jogadas, 4th with igual=0 -> db_estado=E, errou=1, acertou=0, conta_c pulses exactly 3 times.
- In fim_errou pulse iniciar -> preparacao then espera; in espera assert iniciar alone -> no state change.
- Reset asserted in registra (between clocks) -> db_estado=0 and registra_r=0 without waiting for a clock edge.
- TIMEOUT_EN with TIMEOUT_CICLOS=10:
  - No jogada -> db_estado=D and timeout=1 exactly 10 cycles after entering espera.
  - jogada on cycle 10 -> registra, timeout=0.
